// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: oversampled, majority-voted, with start-glitch
// rejection, optional parity, 1 or 2 stop bits and a valid/ready holding
// register carrying per-word parity/framing flags and an overrun pulse.
module uart_rx_param #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_pin_in,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 rx_busy
);

  localparam int DIV   = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int OS_W  = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0]  S_LO     = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0]  S_MID    = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0]  S_HI     = OS_W'(OVERSAMPLE / 2 + 1);
  // Bit counter is 4 bits so it can index up to 9 data bits.
  localparam logic [3:0]       BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic             STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic             ODD       = (PARITY == 1);

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_PAR   = 3'd3;
  localparam logic [2:0] ST_STOP  = 3'd4;
  localparam logic [2:0] ST_BREAK = 3'd5;

  logic                 sync1, sync2, sync_d;
  logic                 rx_s, fall;
  logic [2:0]           state;
  logic [DIV_W-1:0]     div_cnt;
  logic [OS_W-1:0]      os_cnt;
  logic                 tick, vote_tick, end_tick;
  logic                 samp_a, samp_b, vote;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_err_r, frm_err_r;
  logic                 par_bad, complete, ferr_final;

  // Two-flop synchroniser plus a delay flop for falling-edge detection; idle high.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of the others; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1  <= 1'b1;
      sync2  <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      sync1  <= rx_pin_in;
      sync2  <= sync1;
      sync_d <= sync2;
    end
  end

  assign rx_s = sync2;
  assign fall = sync_d & ~sync2;

  // Baud-tick divider and per-bit oversample counter, both parked at 0 in IDLE.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE) begin
      div_cnt <= '0;
      os_cnt  <= '0;
    end else begin
      div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      if (tick) os_cnt <= (os_cnt == OS_LAST) ? '0 : os_cnt + OS_W'(1);
    end
  end

  assign tick      = (state != ST_IDLE) && (div_cnt == DIV_LAST);
  assign vote_tick = tick && (os_cnt == S_HI);
  assign end_tick  = tick && (os_cnt == OS_LAST);

  // Capture the first two mid-bit samples; the third is the live line at S_HI.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a <= 1'b1;
      samp_b <= 1'b1;
    end else if (tick) begin
      if (os_cnt == S_LO)  samp_a <= rx_s;
      if (os_cnt == S_MID) samp_b <= rx_s;
    end
  end

  // Majority vote, parity check and frame-completion decode.
  // NOTE: every signal written in always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    vote       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
    par_bad    = (^shreg) ^ vote ^ ODD;
    complete   = 1'b0;
    ferr_final = frm_err_r | ~vote;
    if (state == ST_STOP && vote_tick && stop_cnt == STOP_LAST) complete = 1'b1;
  end

  // Receive FSM: start qualification, data shift, parity, stop, break.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      rx_busy   <= 1'b0;
      bit_cnt   <= '0;
      stop_cnt  <= 1'b0;
      shreg     <= '0;
      par_err_r <= 1'b0;
      frm_err_r <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (fall) begin
            state     <= ST_START;
            rx_busy   <= 1'b1;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
            par_err_r <= 1'b0;
            frm_err_r <= 1'b0;
          end
        end
        ST_START: begin
          if (vote_tick && vote) begin
            state   <= ST_IDLE;
            rx_busy <= 1'b0;
          end else if (end_tick) begin
            state <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (vote_tick) shreg <= {vote, shreg[DATA_BITS-1:1]};
          if (end_tick) begin
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              state   <= (PARITY != 0) ? ST_PAR : ST_STOP;
            end else begin
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
        end
        ST_PAR: begin
          if (vote_tick) par_err_r <= par_bad;
          if (end_tick)  state     <= ST_STOP;
        end
        ST_STOP: begin
          if (complete) begin
            // Leave at mid-bit so a back-to-back start edge is not missed.
            state   <= vote ? ST_IDLE : ST_BREAK;
            rx_busy <= ~vote;
          end else begin
            if (vote_tick) frm_err_r <= frm_err_r | ~vote;
            if (end_tick)  stop_cnt  <= stop_cnt + 1'b1;
          end
        end
        ST_BREAK: begin
          if (rx_s) begin
            state   <= ST_IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state   <= ST_IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

  // Holding register: load on completion if free or being drained, else flag overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (complete) begin
        if (!rx_valid || rx_ready) begin
          rx_data    <= shreg;
          parity_err <= (PARITY != 0) ? par_err_r : 1'b0;
          frame_err  <= ferr_final;
          rx_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx_param.md
# uart_rx_param

Parametrised UART receiver, the next generation of the fixed 8N1 receive path. Takes the asynchronous serial pin and oversamples it with an internal baud-tick generator. Rejects start-bit glitches, majority-votes each bit and supports configurable data width, parity and stop bits. Delivers each word through a valid/ready holding register with per-word parity/framing flags and an overrun indication, to the design's command/data parser.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz
- BAUD, 115_200: line rate in bit/s
- OVERSAMPLE, 16: ticks per bit; even, 8..32
- DATA_BITS, 8: data bits per frame, 5..9
- PARITY, 0: 0 none, 1 odd, 2 even
- STOP_BITS, 1: 1 or 2

- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- rx_pin_in  in  1  asynchronous serial line, idle high
- rx_data  out  DATA_BITS  received word, LSB first on the line
- rx_valid  out  1  rx_data/flags hold an unconsumed word
- rx_ready  in  1  consumer accepts the word when rx_valid && rx_ready
- parity_err  out  1  held word failed parity; 0 when PARITY=0
- frame_err  out  1  held word had a 0 in a stop-bit sample
- overrun  out  1  one-cycle pulse when a completed word is dropped
- rx_busy  out  1  high from start-bit detection until return to IDLE

## Operation
- Input path: 2-flop synchroniser, then one more register for H→L edge detection. All logic uses the synchronised value.
- Tick generator: DIV = CLK_FREQ/(BAUD*OVERSAMPLE), integer floor, with a counter 0..DIV-1. One-cycle tick at DIV-1. The counter is held at 0 in IDLE and restarts at 0 on start detection.
- Tick counter per bit: 0..OVERSAMPLE-1. The bit value is the majority of the samples at ticks OS/2-1, OS/2 and OS/2+1. The bit is committed at tick OVERSAMPLE-1.
- FSM: IDLE, START, DATA, PARITY, STOP, BREAK.
  - IDLE→START on a synchronised H→L edge.
  - START: if the voted value is 1 at OS/2+1, it is a glitch; go to IDLE with no output. Otherwise go to DATA at the end of the bit.
  - DATA: shift DATA_BITS bits, LSB first. Then go to PARITY if PARITY≠0, else STOP.
  - PARITY: compare the voted bit with the computed parity. Odd means the XOR of data and parity bits is 1; even means it is 0.
  - STOP: sample STOP_BITS stop bits. The frame completes at the mid-bit vote of the last stop bit (tick OS/2+1), not at the bit end, so back-to-back frames are not missed.
  - On completion: go to IDLE if the last vote was 1. If it was 0, go to BREAK.
  - BREAK: wait until the synchronised line is 1, then go to IDLE.
- Frame error: frame_err is set if any stop vote is 0.
- Holding register: on frame completion, if rx_valid=0 or rx_ready=1 in the same cycle, load rx_data, parity_err and frame_err, and set rx_valid. Otherwise drop the new word and pulse overrun. The held word is kept.
- rx_valid clears on a handshake with no simultaneous load.

## Timing
- Reset (synchronous, takes effect at the next edge):
  - FSM goes to IDLE from any state, including mid-frame; counters go to 0.
  - rx_data=0, rx_valid=0, parity_err=0, frame_err=0, overrun=0, rx_busy=0.
  - Synchroniser flops go to 1.
- Start detection latency: 3 clocks after the pin falls (synchroniser plus edge register). rx_busy rises the cycle after detection.
- rx_valid rises 1 clock after the completing vote tick. rx_data and flags are stable while rx_valid=1.
- rx_busy falls in the same cycle the FSM enters IDLE.
- Simultaneous completion and handshake: the new word loads and rx_valid stays 1. No overrun.
- A frame that starts while rx_valid=1 is still received; only its completion is subject to the overrun rule.
- Width rule: DATA_BITS=9 with PARITY≠0 gives an 11- or 12-bit frame. The bit counter is sized for up to 9 data bits.

## Test plan
All tests use default parameters: DIV=27, bit period 432 clocks.
- 8N1 frame 0xA5, rx_ready=1 → one rx_valid cycle, rx_data=0xA5, parity_err=0, frame_err=0.
- PARITY=2, frame 0x03 with parity bit 1 → rx_data=0x03, parity_err=1. The same frame with parity bit 0 → parity_err=0.
- Frame 0x00 with stop bit 0, line held low for 2000 clocks → frame_err=1, FSM in BREAK, no second frame until the line returns high. A following 0x5A is received correctly.
- Low glitch of 100 clocks (shorter than half a bit) → no rx_valid, rx_busy high then low within 1 bit period.
- rx_ready=0, frames 0x11 then 0x22 back-to-back → rx_data stays 0x11 and overrun pulses once. Raising rx_ready then drops rx_valid.
- rst asserted mid-DATA of 0xFF, released, then frame 0x3C → all outputs 0 after reset and 0x3C received with no error flags.
